// File: rtl/pair_mon_pkg.sv
// Shared types and default sizing for the pair compare monitor.
package pair_mon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MATCH    = 2'd1,
    MISMATCH = 2'd2,
    FAULT    = 2'd3
  } pm_state_e;

  localparam int DEF_CNT_W        = 8;
  localparam int DEF_FAULT_THRESH = 3;
  localparam int DEF_HIST_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (inc && !(&q))    q <= q + 1'b1;
  end

endmodule

// File: rtl/pair_compare_monitor.sv
// Compares an expected/actual bit pair per enabled sample; counts, tracks mismatch
// runs and latches a sticky fault. Define PAIR_MON_HISTORY_EN for the hist port.
module pair_compare_monitor
  import pair_mon_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int HIST_W       = DEF_HIST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             exp_bit,
  input  logic             act_bit,
  output logic             mismatch,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
`ifdef PAIR_MON_HISTORY_EN
  ,
  output logic [HIST_W-1:0] hist
`endif
);

  logic             diff, take;
  logic [CNT_W-1:0] run, run_nxt;
  pm_state_e        cur, nxt;

  assign diff = exp_bit ^ act_bit;
  assign take = sample_en & ~clear;

  sat_counter #(.W(CNT_W)) u_sample (
    .clk(clk), .rst(rst), .clr(clear), .inc(take), .q(sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch (
    .clk(clk), .rst(rst), .clr(clear), .inc(take & diff), .q(mismatch_cnt)
  );

  // A matching sample ends the current run of mismatches.
  sat_counter #(.W(CNT_W)) u_run (
    .clk(clk), .rst(rst), .clr(clear | (sample_en & ~diff)), .inc(take & diff), .q(run)
  );

  // Value the run counter will hold after this edge if the sample mismatches.
  assign run_nxt = (&run) ? run : run + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (clear)
      nxt = IDLE;
    else if (sample_en && cur != FAULT) begin
      if (!diff)                                 nxt = MATCH;
      else if (run_nxt >= CNT_W'(FAULT_THRESH))  nxt = FAULT;
      else                                       nxt = MISMATCH;
    end
  end

  always_comb begin
    state = cur;
    fault = (cur == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mismatch <= 1'b0;
    else     mismatch <= take & diff;
  end

`ifdef PAIR_MON_HISTORY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hist <= '0;
    else if (clear)     hist <= '0;
    else if (sample_en) hist <= {hist[HIST_W-2:0], diff};
  end
`endif

endmodule

// File: tb/tb_pair_compare_monitor.sv
// Bench for pair_compare_monitor: a default instance and a CNT_W=3/FAULT_THRESH=7
// instance share stimulus and are checked against a behavioural model each cycle.
module tb_pair_compare_monitor;

  logic clk = 1'b0;
  logic rst, clear, sample_en, exp_bit, act_bit;

  logic       mm0, f0, mm1, f1;
  logic [1:0] st0, st1;
  logic [7:0] sc0, mc0;
  logic [2:0] sc1, mc1;
`ifdef PAIR_MON_HISTORY_EN
  logic [7:0] h0, h1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pair_compare_monitor dut0 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .exp_bit(exp_bit), .act_bit(act_bit), .mismatch(mm0), .fault(f0),
    .state(st0), .sample_cnt(sc0), .mismatch_cnt(mc0)
`ifdef PAIR_MON_HISTORY_EN
    , .hist(h0)
`endif
  );

  pair_compare_monitor #(.CNT_W(3), .FAULT_THRESH(7)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .exp_bit(exp_bit), .act_bit(act_bit), .mismatch(mm1), .fault(f1),
    .state(st1), .sample_cnt(sc1), .mismatch_cnt(mc1)
`ifdef PAIR_MON_HISTORY_EN
    , .hist(h1)
`endif
  );

  // Behavioural model, one slot per instance.
  int         maxv [2] = '{255, 7};
  int         thr  [2] = '{3, 7};
  int         samp [2], mis [2], runl [2];
  bit         flt [2], seen [2], lastd [2], mflag [2];
  logic [7:0] hm [2];

  function automatic int exp_state(int k);
    if (flt[k])        return 3;
    if (!seen[k])      return 0;
    if (!lastd[k])     return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      samp[k] = 0; mis[k] = 0; runl[k] = 0;
      flt[k] = 0; seen[k] = 0; lastd[k] = 0; mflag[k] = 0; hm[k] = '0;
    end
  endtask

  task automatic model_edge(bit c, bit en, bit d);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        samp[k] = 0; mis[k] = 0; runl[k] = 0;
        flt[k] = 0; seen[k] = 0; lastd[k] = 0; mflag[k] = 0; hm[k] = '0;
      end else if (en) begin
        if (samp[k] < maxv[k]) samp[k]++;
        if (d) begin
          if (mis[k] < maxv[k])  mis[k]++;
          if (runl[k] < maxv[k]) runl[k]++;
          if (runl[k] >= thr[k]) flt[k] = 1;
        end else
          runl[k] = 0;
        seen[k] = 1; lastd[k] = d; mflag[k] = d;
        hm[k] = {hm[k][6:0], d};
      end else
        mflag[k] = 0;
    end
  endtask

  task automatic chk(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".state0"}, int'(st0), exp_state(0));
    chk({tag, ".fault0"}, int'(f0), int'(flt[0]));
    chk({tag, ".mm0"},    int'(mm0), int'(mflag[0]));
    chk({tag, ".samp0"},  int'(sc0), samp[0]);
    chk({tag, ".mis0"},   int'(mc0), mis[0]);
    chk({tag, ".state1"}, int'(st1), exp_state(1));
    chk({tag, ".fault1"}, int'(f1), int'(flt[1]));
    chk({tag, ".mm1"},    int'(mm1), int'(mflag[1]));
    chk({tag, ".samp1"},  int'(sc1), samp[1]);
    chk({tag, ".mis1"},   int'(mc1), mis[1]);
`ifdef PAIR_MON_HISTORY_EN
    chk({tag, ".hist0"},  int'(h0), int'(hm[0]));
    chk({tag, ".hist1"},  int'(h1), int'(hm[1]));
`endif
  endtask

  // Drive one cycle of inputs away from the edge, then check just after it.
  task automatic step(string tag, bit c, bit en, bit d);
    @(negedge clk);
    clear = c; sample_en = en;
    exp_bit = $urandom_range(0, 1);
    act_bit = exp_bit ^ d;
    @(posedge clk);
    model_edge(c, en, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sample_en = 1'b0; exp_bit = 1'b0; act_bit = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Four matching samples
    for (int i = 0; i < 4; i++) step("match4", 0, 1, 0);
    chk("match4.state_is_match", int'(st0), 1);
    chk("match4.cnt_is_4", int'(sc0), 4);

    // diff 1,1,0,1,1,1 then a match that must not leave FAULT
    step("clr_a", 1, 0, 0);
    step("seq1", 0, 1, 1);
    step("seq2", 0, 1, 1);
    step("seq3", 0, 1, 0);
    step("seq4", 0, 1, 1);
    step("seq5", 0, 1, 1);
    chk("seq5.not_fault", int'(f0), 0);
    step("seq6", 0, 1, 1);
    chk("seq6.fault", int'(f0), 1);
    chk("seq6.miscnt", int'(mc0), 5);
    step("seq_after", 0, 1, 0);
    chk("seq_after.stays_fault", int'(st0), 3);

    // clear beats a mismatching sample in the same cycle
    step("clr_with_sample", 1, 1, 1);
    chk("clr_with_sample.idle", int'(st0), 0);

    // Nine mismatches: 3-bit counters saturate, fault on the 7th
    for (int i = 0; i < 9; i++) begin
      step("sat", 0, 1, 1);
      if (i == 5) chk("sat.no_fault_at_6", int'(f1), 0);
      if (i == 6) chk("sat.fault_at_7", int'(f1), 1);
    end
    chk("sat.samp_sat", int'(sc1), 7);
    chk("sat.mis_sat", int'(mc1), 7);

    // Async reset between edges with mismatch_cnt=2
    step("clr_b", 1, 0, 0);
    step("pre_rst1", 0, 1, 1);
    step("pre_rst2", 0, 1, 1);
    @(negedge clk);
    clear = 1'b0; sample_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("post_rst", 0, 1, 0);
    chk("post_rst.match", int'(st0), 1);
    chk("post_rst.cnt1", int'(sc0), 1);

    // History pattern 1,0,(gap),1,1
    step("clr_c", 1, 0, 0);
    step("hist1", 0, 1, 1);
    step("hist0", 0, 1, 0);
    step("hist_gap", 0, 0, 1);
    chk("hist_gap.mm_low", int'(mm0), 0);
    step("hist1b", 0, 1, 1);
    step("hist1c", 0, 1, 1);
`ifdef PAIR_MON_HISTORY_EN
    chk("hist.pattern", int'(h0[3:0]), 4'b1011);
`endif

    // Randomised traffic
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_compare_monitor.md
# pair_compare_monitor

Sequential checker on the consuming end of a dual-output stimulus pair: each sampled cycle it compares an expected bit (continuous-assign path) with an actual bit (procedural-block path). It counts samples and mismatches, tracks consecutive-mismatch runs and latches a sticky fault. It sits beside any two-implementation DUT, such as assign-vs-always equivalence benches, and gives a registered pass/fail summary for waveform dumps and bench assertions.

## Interface
Parameters:
- CNT_W, 8, width of all counters; all saturate at 2^CNT_W-1.
- FAULT_THRESH, 3, consecutive mismatches that trigger FAULT; legal range 1 .. 2^CNT_W-1.
- HIST_W, 8, depth of the compare-history shift register (only used with PAIR_MON_HISTORY_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous clear of all state and counters.
- sample_en  in  1  compare exp_bit vs act_bit this cycle.
- exp_bit  in  1  expected value.
- act_bit  in  1  observed value.
- mismatch  out  1  registered one-cycle flag: the last enabled sample differed.
- fault  out  1  sticky, high while state is FAULT.
- state  out  2  IDLE=0, MATCH=1, MISMATCH=2, FAULT=3.
- sample_cnt  out  CNT_W  enabled samples since reset/clear.
- mismatch_cnt  out  CNT_W  mismatching samples since reset/clear.
- hist  out  HIST_W  last HIST_W compare results, 1 = mismatch, bit 0 newest (only with macro).

## Operation
- diff = exp_bit ^ act_bit. It is evaluated only when sample_en=1 and clear=0.
- Enabled sample:
  - mismatch <= diff.
  - sample_cnt +1 (saturating).
  - mismatch_cnt +1 if diff (saturating).
  - Internal run counter: +1 on diff (saturating), 0 on match.
- sample_en=0: mismatch <= 0; counters, run and state hold.
- State transitions on an enabled sample:
  - IDLE/MATCH/MISMATCH, diff=0 -> MATCH.
  - IDLE/MATCH/MISMATCH, diff=1 -> FAULT if the new run value >= FAULT_THRESH, else MISMATCH.
  - FAULT -> FAULT. Only clear or rst exits FAULT. Counters keep running in FAULT.
- FAULT_THRESH=1: the first mismatch enters FAULT directly from any state.
- clear has priority over sample_en in the same cycle. The sample in that cycle is discarded, and every register returns to its reset value.
- Saturated counters stay at all-ones; they never wrap.

## Timing
- All outputs are registered and update on the clk edge where the sample is taken. Latency from inputs to outputs is 1 cycle.
- rst asserts asynchronously and forces these values immediately:
  - state=IDLE; mismatch=0; fault=0.
  - sample_cnt=0; mismatch_cnt=0; run=0; hist=0.
- Release of rst is assumed synchronous to clk, handled externally.
- rst mid-run: all history is lost; the first post-reset sample behaves as from IDLE.
- clear takes effect on the next clk edge; outputs show reset values 1 cycle after clear is sampled.
- fault rises in the same cycle that state becomes FAULT.

## Configuration
- PAIR_MON_HISTORY_EN defined:
  - hist port exists.
  - On each enabled sample: hist <= {hist[HIST_W-2:0], diff}.
  - hist holds when sample_en=0.
  - Cleared by clear/rst.
- Undefined: no hist port and no shift register; all other behaviour is identical.

## Structure
- Package pair_mon_pkg holds:
  - the state typedef/encoding (IDLE, MATCH, MISMATCH, FAULT);
  - the default CNT_W/FAULT_THRESH/HIST_W constants.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output q). It is instantiated three times: sample, mismatch and run.
- run uses clr = clear | (sample_en & ~diff).

## Test plan
- Reset, then 4 enabled samples with exp=1, act=1 -> state=MATCH, sample_cnt=4, mismatch_cnt=0, mismatch=0, fault=0.
- Defaults; sequence diff 1,1,0,1,1,1 -> states MISMATCH, MISMATCH, MATCH, MISMATCH, MISMATCH, FAULT; mismatch_cnt=5; fault=1 on the 6th edge; a further match sample keeps state=FAULT.
- clear and sample_en (diff=1) in the same cycle while in FAULT -> next cycle state=IDLE, all counters 0, mismatch=0.
- CNT_W=3, 9 mismatching samples with FAULT_THRESH=7 -> sample_cnt and mismatch_cnt saturate at 7, no wrap, FAULT entered on the 7th sample.
- rst pulsed asynchronously between clk edges with mismatch_cnt=2 -> outputs zero before the next edge; the next diff=0 sample gives state=MATCH, sample_cnt=1.
- With PAIR_MON_HISTORY_EN and HIST_W=4: diff 1,0,1,1 with a sample_en=0 gap inserted -> hist=4'b1011; the gap cycle leaves hist unchanged and mismatch=0.
